// File: rtl/axi_mem_arbiter_if.sv
// axi_mem_arbiter_if: AXI4 five-channel bundle with master and slave views
interface axi_mem_arbiter_if #(
  parameter int ID_W = 4,
  parameter int DATA_W = 64,
  parameter int ADDR_W = 64,
  parameter int USER_W = 1
);
  logic [ID_W-1:0] awid, bid, arid, rid;
  logic [ADDR_W-1:0] awaddr, araddr;
  logic [7:0] awlen, arlen;
  logic [2:0] awsize, arsize, awprot, arprot;
  logic [1:0] awburst, arburst, bresp, rresp;
  logic awlock, arlock;
  logic [3:0] awcache, arcache, awqos, arqos, awregion, arregion;
  logic [5:0] awatop;
  logic [USER_W-1:0] awuser, wuser, buser, aruser, ruser;
  logic [DATA_W-1:0] wdata, rdata;
  logic [DATA_W/8-1:0] wstrb;
  logic awvalid, awready, wlast, wvalid, wready, bvalid, bready;
  logic arvalid, arready, rlast, rvalid, rready;
  modport master (
    output awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awqos, awregion, awatop, awuser, awvalid,
    output wdata, wstrb, wlast, wuser, wvalid, bready,
    output arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arqos, arregion, aruser, arvalid, rready,
    input awready, wready, bid, bresp, buser, bvalid, arready, rid, rdata, rresp, rlast, ruser, rvalid
  );
  modport slave (
    input awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awqos, awregion, awatop, awuser, awvalid,
    input wdata, wstrb, wlast, wuser, wvalid, bready,
    input arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arqos, arregion, aruser, arvalid, rready,
    output awready, wready, bid, bresp, buser, bvalid, arready, rid, rdata, rresp, rlast, ruser, rvalid
  );
endinterface

// File: rtl/axi_mem_arbiter.sv
// axi_mem_arbiter: two-to-one AXI4 arbiter, ID widened by one bit to route responses
module axi_mem_arbiter #(
  parameter int AXI_ID_WIDTH = 4,
  parameter int AXI_DATA_WIDTH = 64,
  parameter int AXI_ADDR_WIDTH = 64
) (
  input logic clk_i,
  input logic rst_ni,
  axi_mem_arbiter_if.slave s0,
  axi_mem_arbiter_if.slave s1,
  axi_mem_arbiter_if.master m
);
  typedef enum logic {IDLE, GRANT} arb_t;
  typedef enum logic {W_IDLE, W_DATA} wst_t;
  arb_t ar_state, ar_next, aw_state, aw_next;
  wst_t w_state, w_next;
  logic ar_sel, ar_sel_n, ar_last, ar_last_n;
  logic aw_sel, aw_sel_n, aw_last, aw_last_n;
  logic wsel, wsel_n;
  logic ar_gnt, aw_gnt, w_act;
  logic [AXI_ADDR_WIDTH-1:0] ar_addr, aw_addr;
  logic [AXI_DATA_WIDTH-1:0] w_data;
  logic [AXI_DATA_WIDTH/8-1:0] w_strb;
  assign ar_gnt = ar_state == GRANT;
  assign aw_gnt = aw_state == GRANT;
  assign w_act = w_state == W_DATA;
  // arbitration and write-lock state, cleared asynchronously; last=1 lets port 0 win the first tie
  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) begin
      ar_state <= IDLE;
      aw_state <= IDLE;
      w_state <= W_IDLE;
      ar_sel <= 1'b0;
      aw_sel <= 1'b0;
      wsel <= 1'b0;
      ar_last <= 1'b1;
      aw_last <= 1'b1;
    end else begin
      ar_state <= ar_next;
      aw_state <= aw_next;
      w_state <= w_next;
      ar_sel <= ar_sel_n;
      aw_sel <= aw_sel_n;
      wsel <= wsel_n;
      ar_last <= ar_last_n;
      aw_last <= aw_last_n;
    end
  // AR arbiter: one idle cycle to pick a winner (round-robin on ties), hold grant until handshake
  always_comb begin
    ar_next = ar_state;
    ar_sel_n = ar_sel;
    ar_last_n = ar_last;
    if (!ar_gnt && (s0.arvalid || s1.arvalid)) begin
      ar_sel_n = (s0.arvalid && s1.arvalid) ? !ar_last : s1.arvalid;
      ar_last_n = ar_sel_n;
      ar_next = GRANT;
    end else if (ar_gnt && m.arready) ar_next = IDLE;
  end
  // AW arbiter: same as AR, but may only start while no write burst owns the W channel
  always_comb begin
    aw_next = aw_state;
    aw_sel_n = aw_sel;
    aw_last_n = aw_last;
    if (!aw_gnt && !w_act && (s0.awvalid || s1.awvalid)) begin
      aw_sel_n = (s0.awvalid && s1.awvalid) ? !aw_last : s1.awvalid;
      aw_last_n = aw_sel_n;
      aw_next = GRANT;
    end else if (aw_gnt && m.awready) aw_next = IDLE;
  end
  // W lock: the AW handshake hands W to its port until that port's wlast beat completes
  always_comb begin
    w_next = w_state;
    wsel_n = wsel;
    if (aw_gnt && m.awready) begin
      w_next = W_DATA;
      wsel_n = aw_sel;
    end else if (w_act && m.wvalid && m.wready && m.wlast) w_next = W_IDLE;
  end
  assign ar_addr = ar_sel ? s1.araddr : s0.araddr;
  assign m.arvalid = ar_gnt;
  assign m.arid = {ar_sel, ar_sel ? s1.arid : s0.arid};
  assign m.araddr = ar_addr;
  assign m.arlen = ar_sel ? s1.arlen : s0.arlen;
  assign m.arsize = ar_sel ? s1.arsize : s0.arsize;
  assign m.arburst = ar_sel ? s1.arburst : s0.arburst;
  assign m.arlock = ar_sel ? s1.arlock : s0.arlock;
  assign m.arcache = ar_sel ? s1.arcache : s0.arcache;
  assign m.arprot = ar_sel ? s1.arprot : s0.arprot;
  assign m.arqos = ar_sel ? s1.arqos : s0.arqos;
  assign m.arregion = ar_sel ? s1.arregion : s0.arregion;
  assign m.aruser = ar_sel ? s1.aruser : s0.aruser;
  assign s0.arready = ar_gnt && !ar_sel && m.arready;
  assign s1.arready = ar_gnt && ar_sel && m.arready;
  assign aw_addr = aw_sel ? s1.awaddr : s0.awaddr;
  assign m.awvalid = aw_gnt;
  assign m.awid = {aw_sel, aw_sel ? s1.awid : s0.awid};
  assign m.awaddr = aw_addr;
  assign m.awlen = aw_sel ? s1.awlen : s0.awlen;
  assign m.awsize = aw_sel ? s1.awsize : s0.awsize;
  assign m.awburst = aw_sel ? s1.awburst : s0.awburst;
  assign m.awlock = aw_sel ? s1.awlock : s0.awlock;
  assign m.awcache = aw_sel ? s1.awcache : s0.awcache;
  assign m.awprot = aw_sel ? s1.awprot : s0.awprot;
  assign m.awqos = aw_sel ? s1.awqos : s0.awqos;
  assign m.awregion = aw_sel ? s1.awregion : s0.awregion;
  assign m.awatop = aw_sel ? s1.awatop : s0.awatop;
  assign m.awuser = aw_sel ? s1.awuser : s0.awuser;
  assign s0.awready = aw_gnt && !aw_sel && m.awready;
  assign s1.awready = aw_gnt && aw_sel && m.awready;
  assign w_data = wsel ? s1.wdata : s0.wdata;
  assign w_strb = wsel ? s1.wstrb : s0.wstrb;
  assign m.wvalid = w_act && (wsel ? s1.wvalid : s0.wvalid);
  assign m.wdata = w_data;
  assign m.wstrb = w_strb;
  assign m.wlast = wsel ? s1.wlast : s0.wlast;
  assign m.wuser = wsel ? s1.wuser : s0.wuser;
  assign s0.wready = w_act && !wsel && m.wready;
  assign s1.wready = w_act && wsel && m.wready;
  assign s0.rvalid = m.rvalid && !m.rid[AXI_ID_WIDTH];
  assign s1.rvalid = m.rvalid && m.rid[AXI_ID_WIDTH];
  assign s0.rid = m.rid[AXI_ID_WIDTH-1:0];
  assign s1.rid = m.rid[AXI_ID_WIDTH-1:0];
  assign s0.rdata = m.rdata;
  assign s1.rdata = m.rdata;
  assign s0.rresp = m.rresp;
  assign s1.rresp = m.rresp;
  assign s0.rlast = m.rlast;
  assign s1.rlast = m.rlast;
  assign s0.ruser = m.ruser;
  assign s1.ruser = m.ruser;
  assign m.rready = m.rid[AXI_ID_WIDTH] ? s1.rready : s0.rready;
  assign s0.bvalid = m.bvalid && !m.bid[AXI_ID_WIDTH];
  assign s1.bvalid = m.bvalid && m.bid[AXI_ID_WIDTH];
  assign s0.bid = m.bid[AXI_ID_WIDTH-1:0];
  assign s1.bid = m.bid[AXI_ID_WIDTH-1:0];
  assign s0.bresp = m.bresp;
  assign s1.bresp = m.bresp;
  assign s0.buser = m.buser;
  assign s1.buser = m.buser;
  assign m.bready = m.bid[AXI_ID_WIDTH] ? s1.bready : s0.bready;
endmodule

// File: tb/tb_axi_mem_arbiter.sv
// tb_axi_mem_arbiter: scenario tasks with queue scoreboards for the two-to-one AXI arbiter
module tb_axi_mem_arbiter;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int checks = 0;
  int errors = 0;
  logic [68:0] ar_q[$];
  logic [63:0] w_q[$];
  logic [68:0] r_q[$];
  logic [68:0] exp69, obs69;
  logic [63:0] exp64;

  axi_mem_arbiter_if #(.ID_W(4)) s0 ();
  axi_mem_arbiter_if #(.ID_W(4)) s1 ();
  axi_mem_arbiter_if #(.ID_W(5)) m ();

  axi_mem_arbiter dut (.clk_i(clk), .rst_ni(rst_n), .s0(s0), .s1(s1), .m(m));

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: sim time limit reached, want finish");
    $fatal(1, "timeout");
  end

  task automatic tick;
    @(posedge clk);
    #2;
  endtask

  task automatic clear_inputs;
    {s0.awid, s0.awaddr, s0.awlen, s0.awsize, s0.awburst, s0.awlock, s0.awcache, s0.awprot} = '0;
    {s0.awqos, s0.awregion, s0.awatop, s0.awuser, s0.awvalid} = '0;
    {s0.wdata, s0.wstrb, s0.wlast, s0.wuser, s0.wvalid, s0.bready, s0.rready} = '0;
    {s0.arid, s0.araddr, s0.arlen, s0.arsize, s0.arburst, s0.arlock, s0.arcache, s0.arprot} = '0;
    {s0.arqos, s0.arregion, s0.aruser, s0.arvalid} = '0;
    {s1.awid, s1.awaddr, s1.awlen, s1.awsize, s1.awburst, s1.awlock, s1.awcache, s1.awprot} = '0;
    {s1.awqos, s1.awregion, s1.awatop, s1.awuser, s1.awvalid} = '0;
    {s1.wdata, s1.wstrb, s1.wlast, s1.wuser, s1.wvalid, s1.bready, s1.rready} = '0;
    {s1.arid, s1.araddr, s1.arlen, s1.arsize, s1.arburst, s1.arlock, s1.arcache, s1.arprot} = '0;
    {s1.arqos, s1.arregion, s1.aruser, s1.arvalid} = '0;
    {m.awready, m.wready, m.bid, m.bresp, m.buser, m.bvalid, m.arready} = '0;
    {m.rid, m.rdata, m.rresp, m.rlast, m.ruser, m.rvalid} = '0;
  endtask

  task automatic do_reset;
    clear_inputs();
    #1 rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_reset;
    clear_inputs();
    rst_n = 1'b0;
    #1;
    checks++;
    if ({m.arvalid, m.awvalid, m.wvalid, s0.arready, s1.arready, s0.awready, s1.awready, s0.wready, s1.wready} !== 9'b0) begin
      errors++;
      $display("FAIL reset_outputs: valid/ready=%b want 0", {m.arvalid, m.awvalid, m.wvalid, s0.arready, s1.arready, s0.awready, s1.awready, s0.wready, s1.wready});
    end
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_single_read;
    s0.arvalid = 1'b1; s0.arid = 4'd3; s0.araddr = 64'h1000; m.arready = 1'b1;
    ar_q.push_back({5'h03, 64'h1000});
    #1;
    checks++;
    if (m.arvalid !== 1'b0) begin errors++; $display("FAIL rd_arb_cycle: arvalid=%b want 0", m.arvalid); end
    tick();
    #1;
    exp69 = ar_q.pop_front();
    checks++;
    if (m.arvalid !== 1'b1 || {m.arid, m.araddr} !== exp69 || s0.arready !== 1'b1 || s1.arready !== 1'b0) begin
      errors++;
      $display("FAIL rd_grant: v=%b id/addr=%h rdy=%b%b want 1 %h 10", m.arvalid, {m.arid, m.araddr}, s0.arready, s1.arready, exp69);
    end
    tick();
    s0.arvalid = 1'b0; m.arready = 1'b0;
    m.rvalid = 1'b1; m.rid = 5'h03; m.rdata = 64'hDEAD_BEEF; m.rlast = 1'b1; s0.rready = 1'b1;
    r_q.push_back({1'b0, 4'd3, 64'hDEAD_BEEF});
    #1;
    checks++;
    if (m.arvalid !== 1'b0) begin errors++; $display("FAIL rd_release: arvalid=%b want 0", m.arvalid); end
    exp69 = r_q.pop_front();
    obs69 = s1.rvalid ? {1'b1, s1.rid, s1.rdata} : {1'b0, s0.rid, s0.rdata};
    checks++;
    if (obs69 !== exp69 || s0.rvalid !== 1'b1 || s1.rvalid !== 1'b0 || m.rready !== 1'b1) begin
      errors++;
      $display("FAIL rd_resp: got %h rv=%b%b rr=%b want %h rv=10 rr=1", obs69, s0.rvalid, s1.rvalid, m.rready, exp69);
    end
    tick();
    clear_inputs();
  endtask

  task automatic test_round_robin;
    do_reset();
    s0.arvalid = 1'b1; s0.arid = 4'd1; s0.araddr = 64'hA0;
    s1.arvalid = 1'b1; s1.arid = 4'd2; s1.araddr = 64'hB0;
    for (int g = 0; g < 4; g++) begin
      ar_q.push_back((g % 2 == 1) ? {5'h12, 64'hB0} : {5'h01, 64'hA0});
      #1;
      checks++;
      if (m.arvalid !== 1'b0) begin errors++; $display("FAIL rr_idle_%0d: arvalid=%b want 0", g, m.arvalid); end
      tick();
      if (g == 0) begin
        for (int k = 0; k < 2; k++) begin
          #1;
          checks++;
          if (m.arvalid !== 1'b1 || {m.arid, m.araddr} !== ar_q[0] || s0.arready !== 1'b0 || s1.arready !== 1'b0) begin
            errors++;
            $display("FAIL rr_stall_%0d: v=%b id/addr=%h rdy=%b%b want 1 %h 00", k, m.arvalid, {m.arid, m.araddr}, s0.arready, s1.arready, ar_q[0]);
          end
          tick();
        end
        m.arready = 1'b1;
      end
      #1;
      exp69 = ar_q.pop_front();
      checks++;
      if ({m.arid, m.araddr} !== exp69 || {s1.arready, s0.arready} !== ((g % 2 == 1) ? 2'b10 : 2'b01)) begin
        errors++;
        $display("FAIL rr_grant_%0d: id/addr=%h rdy=%b%b want %h port %0d", g, {m.arid, m.araddr}, s1.arready, s0.arready, exp69, g % 2);
      end
      tick();
    end
    clear_inputs();
  endtask

  task automatic test_write_lock;
    s1.awvalid = 1'b1; s1.awid = 4'd5; s1.awlen = 8'd3; s1.awaddr = 64'h2000;
    m.awready = 1'b1; m.wready = 1'b1;
    tick();
    #1;
    checks++;
    if (m.awvalid !== 1'b1 || m.awid !== 5'h15 || s1.awready !== 1'b1) begin
      errors++;
      $display("FAIL wl_aw1: v=%b id=%h rdy=%b want 1 15 1", m.awvalid, m.awid, s1.awready);
    end
    tick();
    s1.awvalid = 1'b0;
    s0.awvalid = 1'b1; s0.awid = 4'd7; s0.awlen = 8'd0; s0.awaddr = 64'h3000;
    for (int b = 0; b < 4; b++) begin
      s1.wvalid = 1'b1; s1.wdata = 64'h100 + 64'(b); s1.wstrb = 8'hFF; s1.wlast = (b == 3);
      w_q.push_back(64'h100 + 64'(b));
      #1;
      exp64 = w_q.pop_front();
      checks++;
      if (m.wvalid !== 1'b1 || m.wdata !== exp64 || s1.wready !== 1'b1 || s0.wready !== 1'b0 || m.awvalid !== 1'b0 || s0.awready !== 1'b0) begin
        errors++;
        $display("FAIL wl_beat_%0d: wv=%b data=%h wr=%b%b awv=%b want 1 %h 10 0", b, m.wvalid, m.wdata, s1.wready, s0.wready, m.awvalid, exp64);
      end
      tick();
    end
    s1.wvalid = 1'b0; s1.wlast = 1'b0;
    #1;
    checks++;
    if (m.awvalid !== 1'b0) begin errors++; $display("FAIL wl_arb_cycle: awvalid=%b want 0", m.awvalid); end
    tick();
    #1;
    checks++;
    if (m.awvalid !== 1'b1 || {m.awid, m.awaddr} !== {5'h07, 64'h3000} || s0.awready !== 1'b1) begin
      errors++;
      $display("FAIL wl_aw0: v=%b id/addr=%h rdy=%b want 1 %h 1", m.awvalid, {m.awid, m.awaddr}, s0.awready, {5'h07, 64'h3000});
    end
    tick();
    s0.awvalid = 1'b0;
    s0.wvalid = 1'b1; s0.wdata = 64'h55; s0.wstrb = 8'hFF; s0.wlast = 1'b1;
    w_q.push_back(64'h55);
    #1;
    exp64 = w_q.pop_front();
    checks++;
    if (m.wvalid !== 1'b1 || m.wdata !== exp64 || s0.wready !== 1'b1 || s1.wready !== 1'b0) begin
      errors++;
      $display("FAIL wl_p0_beat: wv=%b data=%h wr=%b%b want 1 %h 10", m.wvalid, m.wdata, s0.wready, s1.wready, exp64);
    end
    tick();
    clear_inputs();
  endtask

  task automatic test_w_before_aw;
    s0.wvalid = 1'b1; s0.wdata = 64'hCAFE; s0.wstrb = 8'hF0; s0.wlast = 1'b1; m.wready = 1'b1; m.awready = 1'b1;
    for (int k = 0; k < 2; k++) begin
      #1;
      checks++;
      if (s0.wready !== 1'b0 || m.wvalid !== 1'b0) begin
        errors++;
        $display("FAIL early_w_%0d: wready=%b wvalid=%b want 0 0", k, s0.wready, m.wvalid);
      end
      tick();
    end
    s0.awvalid = 1'b1; s0.awid = 4'd4; s0.awlen = 8'd0;
    tick();
    #1;
    checks++;
    if (s0.awready !== 1'b1 || s0.wready !== 1'b0) begin
      errors++;
      $display("FAIL early_w_awhs: awready=%b wready=%b want 1 0", s0.awready, s0.wready);
    end
    tick();
    s0.awvalid = 1'b0;
    w_q.push_back(64'hCAFE);
    #1;
    exp64 = w_q.pop_front();
    checks++;
    if (s0.wready !== 1'b1 || m.wvalid !== 1'b1 || m.wdata !== exp64 || m.wstrb !== 8'hF0 || m.wlast !== 1'b1) begin
      errors++;
      $display("FAIL early_w_data: wr=%b wv=%b data=%h strb=%h want 1 1 %h f0", s0.wready, m.wvalid, m.wdata, m.wstrb, exp64);
    end
    tick();
    clear_inputs();
  endtask

  task automatic test_r_interleave;
    m.rvalid = 1'b1; m.rid = 5'h12; m.rdata = 64'hAAAA; s1.rready = 1'b0; s0.rready = 1'b1;
    r_q.push_back({1'b1, 4'd2, 64'hAAAA});
    r_q.push_back({1'b0, 4'd2, 64'hBBBB});
    #1;
    checks++;
    if (s1.rvalid !== 1'b1 || s0.rvalid !== 1'b0 || m.rready !== 1'b0) begin
      errors++;
      $display("FAIL ri_backpressure: rv=%b%b rready=%b want 10 0", s1.rvalid, s0.rvalid, m.rready);
    end
    tick();
    s1.rready = 1'b1;
    #1;
    exp69 = r_q.pop_front();
    obs69 = s1.rvalid ? {1'b1, s1.rid, s1.rdata} : {1'b0, s0.rid, s0.rdata};
    checks++;
    if (obs69 !== exp69 || s0.rvalid !== 1'b0 || m.rready !== 1'b1) begin
      errors++;
      $display("FAIL ri_first: got %h rv0=%b rr=%b want %h 0 1", obs69, s0.rvalid, m.rready, exp69);
    end
    tick();
    m.rid = 5'h02; m.rdata = 64'hBBBB; s1.rready = 1'b0;
    #1;
    exp69 = r_q.pop_front();
    obs69 = s1.rvalid ? {1'b1, s1.rid, s1.rdata} : {1'b0, s0.rid, s0.rdata};
    checks++;
    if (obs69 !== exp69 || s1.rvalid !== 1'b0 || m.rready !== 1'b1) begin
      errors++;
      $display("FAIL ri_second: got %h rv1=%b rr=%b want %h 0 1", obs69, s1.rvalid, m.rready, exp69);
    end
    tick();
    m.rvalid = 1'b0;
    m.bvalid = 1'b1; m.bid = 5'h15; m.bresp = 2'b10; s1.bready = 1'b1; s0.bready = 1'b0;
    #1;
    checks++;
    if (s1.bvalid !== 1'b1 || s0.bvalid !== 1'b0 || s1.bid !== 4'd5 || s1.bresp !== 2'b10 || m.bready !== 1'b1) begin
      errors++;
      $display("FAIL b_route: bv=%b%b bid=%h resp=%b br=%b want 10 5 10 1", s1.bvalid, s0.bvalid, s1.bid, s1.bresp, m.bready);
    end
    tick();
    clear_inputs();
  endtask

  task automatic test_reset_mid;
    s0.awvalid = 1'b1; s0.awid = 4'd1; s0.awlen = 8'd3; m.awready = 1'b1;
    tick();
    tick();
    s0.awvalid = 1'b0;
    s0.wvalid = 1'b1; s0.wdata = 64'h1; m.wready = 1'b1;
    s0.arvalid = 1'b1; s0.arid = 4'd1; m.arready = 1'b0;
    tick();
    #1;
    checks++;
    if (m.wvalid !== 1'b1 || m.arvalid !== 1'b1) begin
      errors++;
      $display("FAIL rm_pre: wvalid=%b arvalid=%b want 1 1", m.wvalid, m.arvalid);
    end
    #1 rst_n = 1'b0;
    #1;
    checks++;
    if ({m.arvalid, m.awvalid, m.wvalid, s0.arready, s0.awready, s0.wready, s1.wready} !== 7'b0) begin
      errors++;
      $display("FAIL rm_async: valid/ready=%b want 0", {m.arvalid, m.awvalid, m.wvalid, s0.arready, s0.awready, s0.wready, s1.wready});
    end
    clear_inputs();
    tick();
    rst_n = 1'b1;
    s0.arvalid = 1'b1; s0.arid = 4'd1; s1.arvalid = 1'b1; s1.arid = 4'd2; m.arready = 1'b1;
    tick();
    #1;
    checks++;
    if (m.arid !== 5'h01 || s0.arready !== 1'b1 || s1.arready !== 1'b0) begin
      errors++;
      $display("FAIL rm_first_tie: arid=%h rdy=%b%b want 01 10", m.arid, s0.arready, s1.arready);
    end
    tick();
    clear_inputs();
  endtask

  initial begin
    test_reset();
    test_single_read();
    test_round_robin();
    test_write_lock();
    test_w_before_aw();
    test_r_interleave();
    test_reset_mid();
    checks++;
    if (ar_q.size() + w_q.size() + r_q.size() !== 0) begin
      errors++;
      $display("FAIL scoreboard_drain: %0d entries left want 0", ar_q.size() + w_q.size() + r_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
